// File: rtl/matmul_engine.sv
// matmul_engine: sequential C = A x B with one unsigned MAC per cycle.
// Walks operand rows by async read and writes each finished C row.
module matmul_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [$clog2(BUS_WIDTH/DATA_WIDTH):0] dim_n_i,
    input  logic [$clog2(BUS_WIDTH/DATA_WIDTH):0] dim_k_i,
    input  logic [$clog2(BUS_WIDTH/DATA_WIDTH):0] dim_m_i,
    output logic [ADDR_WIDTH-1:0] a_addr_o,
    input  logic [BUS_WIDTH-1:0]  a_data_i,
    output logic [ADDR_WIDTH-1:0] b_addr_o,
    input  logic [BUS_WIDTH-1:0]  b_data_i,
    output logic                  res_we_o,
    output logic [ADDR_WIDTH-1:0] res_addr_o,
    output logic [BUS_WIDTH-1:0]  res_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  ovf_o
);

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int DW_DIM  = $clog2(MAX_DIM) + 1;
    localparam int ACC_W   = 2 * DATA_WIDTH + DW_DIM;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DW_DIM-1:0]    n_q, n_d;
    logic [DW_DIM-1:0]    kd_q, kd_d;
    logic [DW_DIM-1:0]    m_q, m_d;
    logic [DW_DIM-1:0]    i_q, i_d;
    logic [DW_DIM-1:0]    j_q, j_d;
    logic [DW_DIM-1:0]    k_q, k_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [BUS_WIDTH-1:0] row_q, row_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;

    logic                  dims_ok;
    logic                  last_i;
    logic                  last_j;
    logic                  last_k;
    logic [DATA_WIDTH-1:0] a_elem;
    logic [DATA_WIDTH-1:0] b_elem;
    logic [ACC_W-1:0]      sum;

    // Decode legality of the requested dims and the loop-end conditions
    always_comb begin
        dims_ok = (dim_n_i != '0) && (dim_n_i <= DW_DIM'(MAX_DIM))
               && (dim_k_i != '0) && (dim_k_i <= DW_DIM'(MAX_DIM))
               && (dim_m_i != '0) && (dim_m_i <= DW_DIM'(MAX_DIM));
        last_i  = (i_q == n_q - DW_DIM'(1));
        last_j  = (j_q == m_q - DW_DIM'(1));
        last_k  = (k_q == kd_q - DW_DIM'(1));
    end

    // Pick A[i][k] and B[k][j] out of the current operand rows
    always_comb begin
        a_elem = '0;
        b_elem = '0;
        for (int e = 0; e < MAX_DIM; e++) begin
            if (k_q == DW_DIM'(e)) begin
                a_elem = a_data_i[e*DATA_WIDTH +: DATA_WIDTH];
            end
            if (j_q == DW_DIM'(e)) begin
                b_elem = b_data_i[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        sum = acc_q + ACC_W'(a_elem) * ACC_W'(b_elem);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && dims_ok) begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (last_k && last_j) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = last_i ? S_DONE : S_COMPUTE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, accumulator, row buffer and flag updates
    always_comb begin
        n_d   = n_q;
        kd_d  = kd_q;
        m_d   = m_q;
        i_d   = i_q;
        j_d   = j_q;
        k_d   = k_q;
        acc_d = acc_q;
        row_d = row_q;
        err_d = 1'b0;
        ovf_d = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && dims_ok) begin
                    n_d   = dim_n_i;
                    kd_d  = dim_k_i;
                    m_d   = dim_m_i;
                    i_d   = '0;
                    j_d   = '0;
                    k_d   = '0;
                    acc_d = '0;
                    row_d = '0;
                    ovf_d = 1'b0;
                end else if (start_i) begin
                    err_d = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (last_k) begin
                    for (int e = 0; e < MAX_DIM; e++) begin
                        if (j_q == DW_DIM'(e)) begin
                            row_d[e*DATA_WIDTH +: DATA_WIDTH] =
                                sum[DATA_WIDTH-1:0];
                        end
                    end
                    if (|sum[ACC_W-1:DATA_WIDTH]) begin
                        ovf_d = 1'b1;
                    end
                    acc_d = '0;
                    k_d   = '0;
                    if (!last_j) begin
                        j_d = j_q + DW_DIM'(1);
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + DW_DIM'(1);
                end
            end
            S_WRITE: begin
                row_d = '0;
                j_d   = '0;
                if (!last_i) begin
                    i_d = i_q + DW_DIM'(1);
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            n_q   <= '0;
            kd_q  <= '0;
            m_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
            acc_q <= '0;
            row_q <= '0;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            n_q   <= n_d;
            kd_q  <= kd_d;
            m_q   <= m_d;
            i_q   <= i_d;
            j_q   <= j_d;
            k_q   <= k_d;
            acc_q <= acc_d;
            row_q <= row_d;
            err_q <= err_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs decoded from state; addresses are quiet outside their phase
    always_comb begin
        a_addr_o   = '0;
        b_addr_o   = '0;
        res_we_o   = 1'b0;
        res_addr_o = '0;
        res_data_o = '0;
        if (state_q == S_COMPUTE) begin
            a_addr_o = ADDR_WIDTH'(i_q);
            b_addr_o = ADDR_WIDTH'(k_q);
        end
        if (state_q == S_WRITE) begin
            res_we_o   = 1'b1;
            res_addr_o = ADDR_WIDTH'(i_q);
            res_data_o = row_q;
        end
        busy_o = (state_q != S_IDLE);
        done_o = (state_q == S_DONE);
        err_o  = err_q;
        ovf_o  = ovf_q;
    end

endmodule

// File: tb/tb_matmul_engine.sv
// tb_matmul_engine: directed runs with a result-write scoreboard.
// Expected rows are queued at issue and popped by a write monitor.
module tb_matmul_engine;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  dim_n_i, dim_k_i, dim_m_i;
    logic [31:0] a_addr_o, b_addr_o, res_addr_o;
    logic [63:0] a_data_i, b_data_i, res_data_o;
    logic        res_we_o, busy_o, done_o, err_o, ovf_o;

    logic [63:0] mem_a [2];
    logic [63:0] mem_b [2];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    matmul_engine dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .dim_n_i    (dim_n_i),
        .dim_k_i    (dim_k_i),
        .dim_m_i    (dim_m_i),
        .a_addr_o   (a_addr_o),
        .a_data_i   (a_data_i),
        .b_addr_o   (b_addr_o),
        .b_data_i   (b_data_i),
        .res_we_o   (res_we_o),
        .res_addr_o (res_addr_o),
        .res_data_o (res_data_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    assign a_data_i = (a_addr_o < 2) ? mem_a[a_addr_o[0]] : 64'h0;
    assign b_data_i = (b_addr_o < 2) ? mem_b[b_addr_o[0]] : 64'h0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Write monitor: every result write must match the queue head
    always @(negedge clk_i) begin
        if (res_we_o) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h expected none",
                         res_addr_o, res_data_o);
            end else begin
                wr_t w;
                w = sb.pop_front();
                chk("wr_addr", {32'h0, res_addr_o}, {32'h0, w.addr});
                chk("wr_data", res_data_o, w.data);
            end
        end
    end

    task automatic push(input logic [31:0] a, input logic [63:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    task automatic load_2x2();
        mem_a[0] = 64'h00000002_00000001;
        mem_a[1] = 64'h00000004_00000003;
        mem_b[0] = 64'h00000006_00000005;
        mem_b[1] = 64'h00000008_00000007;
        push(32'd0, 64'h00000016_00000013);
        push(32'd1, 64'h00000032_0000002B);
    endtask

    task automatic run(input int n, input int k, input int m,
                       input int exp_cyc, input bit mid_start);
        int done_c;
        done_c = 0;
        dim_n_i = 2'(n);
        dim_k_i = 2'(k);
        dim_m_i = 2'(m);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("busy_c1", {63'h0, busy_o}, 64'h1);
        for (int c = 1; c < 200; c++) begin
            if (mid_start) start_i = (c == 2);
            if (done_o) begin
                done_c = c;
                break;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        if (done_c == 0) begin
            chk("done_timeout", 64'h0, 64'h1);
        end else begin
            chk("done_cycle", 64'(done_c), 64'(exp_cyc));
            @(negedge clk_i);
            chk("done_pulse", {63'h0, done_o}, 64'h0);
            chk("busy_end", {63'h0, busy_o}, 64'h0);
        end
        chk("sb_empty", 64'(sb.size()), 64'h0);
    endtask

    task automatic illegal(input int kdim);
        dim_n_i = 2'd1;
        dim_k_i = 2'(kdim);
        dim_m_i = 2'd1;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("err_pulse", {63'h0, err_o}, 64'h1);
        chk("err_busy", {63'h0, busy_o}, 64'h0);
        @(negedge clk_i);
        chk("err_clear", {63'h0, err_o}, 64'h0);
        chk("err_ovf_kept", {63'h0, ovf_o}, 64'h1);
    endtask

    task automatic chk_quiet(input string nm);
        chk(nm, {a_addr_o, b_addr_o}, 64'h0);
        chk(nm, {32'h0, res_addr_o}, 64'h0);
        chk(nm, res_data_o, 64'h0);
        chk(nm, {59'h0, res_we_o, busy_o, done_o, err_o, ovf_o}, 64'h0);
    endtask

    initial begin
        int done_seen;
        rst_i   = 1'b1;
        start_i = 1'b0;
        dim_n_i = '0;
        dim_k_i = '0;
        dim_m_i = '0;
        mem_a[0] = '0;
        mem_a[1] = '0;
        mem_b[0] = '0;
        mem_b[1] = '0;
        repeat (3) @(negedge clk_i);
        chk_quiet("reset_state");
        rst_i = 1'b0;

        load_2x2();
        run(2, 2, 2, 11, 1'b0);
        chk("ovf_2x2", {63'h0, ovf_o}, 64'h0);

        mem_a[0] = 64'h00000004_00000003;
        mem_b[0] = 64'h00000009_00000005;
        mem_b[1] = 64'h00000009_00000006;
        push(32'd0, 64'h00000000_00000027);
        run(1, 2, 1, 4, 1'b0);

        mem_a[0] = 64'h00000000_FFFFFFFF;
        mem_b[0] = 64'h00000000_FFFFFFFF;
        push(32'd0, 64'h00000000_00000001);
        run(1, 1, 1, 3, 1'b0);
        chk("ovf_set", {63'h0, ovf_o}, 64'h1);
        repeat (3) @(negedge clk_i);
        chk("ovf_sticky", {63'h0, ovf_o}, 64'h1);

        illegal(0);
        illegal(3);

        load_2x2();
        run(2, 2, 2, 11, 1'b1);
        chk("ovf_cleared", {63'h0, ovf_o}, 64'h0);

        mem_a[0] = 64'h00000002_00000001;
        dim_n_i = 2'd2;
        dim_k_i = 2'd2;
        dim_m_i = 2'd2;
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_quiet("rst_abort");
        rst_i = 1'b0;
        done_seen = 0;
        repeat (15) begin
            @(negedge clk_i);
            if (done_o) done_seen++;
        end
        chk("no_done_after_rst", 64'(done_seen), 64'h0);

        load_2x2();
        run(2, 2, 2, 11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
